// File: rtl/stack_ram_responder.sv
// 128x8 stack/data store for the stack calculator controller: zero-fill sweep after reset, 1-cycle reads, ack per access.
// Optional macro STACK_RAM_PARITY_EN adds a stored even-parity bit, a parity-inject write strobe and a par_err flag on reads.
module stack_ram_responder #(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ack,
  output logic              busy,
  output logic              err,
  input  logic              inj_par,
  output logic              par_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef STACK_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                par_err_q, par_err_d;

  logic [MEM_W-1:0]    mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [MEM_W-1:0]    mem_wdata;
  logic [MEM_W-1:0]    rd_word;
  logic [MEM_W-1:0]    init_word;
  logic [MEM_W-1:0]    wr_word;
  logic                access;

`ifdef STACK_RAM_PARITY_EN
  assign init_word = {^INIT_VAL, INIT_VAL};
  assign wr_word   = {(^data_in) ^ inj_par, data_in};
`else
  logic unused_inj_par;
  assign unused_inj_par = inj_par;
  assign init_word      = INIT_VAL;
  assign wr_word        = data_in;
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // FSM: next state; IDLE is left only through reset
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    state_d = state_q;
    case (state_q)
      ST_INIT: if (ptr_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy   = (state_q == ST_INIT);
    access = (state_q == ST_IDLE) && cs;
  end

  // Sweep owns the write port while busy; requests are dropped, never merged.
  always_comb begin
    rd_word = mem[address];
    ptr_d   = busy ? ptr_q + 1'b1 : ptr_q;
    if (busy) begin
      mem_we    = 1'b1;
      mem_addr  = ptr_q;
      mem_wdata = init_word;
    end else begin
      mem_we    = access && we;
      mem_addr  = address;
      mem_wdata = wr_word;
    end
  end

  always_comb begin
    ack_d      = access;
    err_d      = err_q | (busy & cs);
    data_out_d = data_out_q;
    if (access) data_out_d = we ? data_in : rd_word[DATA_W-1:0];
`ifdef STACK_RAM_PARITY_EN
    par_err_d  = access && !we && (rd_word[DATA_W] != ^rd_word[DATA_W-1:0]);
`else
    par_err_d  = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      data_out_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      par_err_q  <= par_err_d;
    end
  end

  // NOTE: the array has no reset; its known image comes from the init sweep instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign data_out = data_out_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign par_err  = par_err_q;

endmodule

// File: tb/tb_stack_ram_responder.sv
// Directed self-checking bench for stack_ram_responder; parity expectations follow STACK_RAM_PARITY_EN.
module tb_stack_ram_responder;

`ifdef STACK_RAM_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, cs, we, inj_par;
  logic [6:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ack, busy, err, par_err;

  int checks   = 0;
  int failures = 0;

  stack_ram_responder dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .we       (we),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .busy     (busy),
    .err      (err),
    .inj_par  (inj_par),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one access so it is sampled on the next edge; leaves cs high for back-to-back use.
  task automatic acc(input logic w, input logic [6:0] a, input logic [7:0] d, input logic ip);
    cs = 1'b1; we = w; address = a; data_in = d; inj_par = ip;
    tick();
  endtask

  task automatic bus_idle();
    cs = 1'b0; we = 1'b0; inj_par = 1'b0;
  endtask

  // Counts edges until busy drops (bounded) and whether ack was seen meanwhile.
  task automatic wait_idle(output int n, output int acks);
    n = 0; acks = 0;
    while (busy === 1'b1 && n < 400) begin
      tick();
      n++;
      if (ack !== 1'b0) acks++;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n, acks, bad_ack, bad_data, bad_par;
    rst = 1'b1; cs = 1'b0; we = 1'b0; inj_par = 1'b0; address = '0; data_in = '0;
    #2;
    check("rst_data_out", data_out, 8'h00);
    check("rst_ack", ack, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_err", err, 1'b0);
    check("rst_par_err", par_err, 1'b0);
    tick();
    rst = 1'b0;

    // 1: sweep length and zero image
    wait_idle(n, acks);
    check("sweep_len", n, 128);
    check("sweep_acks", acks, 0);
    check("sweep_err", err, 1'b0);
    bad_ack = 0; bad_data = 0; bad_par = 0;
    for (int i = 0; i < 128; i++) begin
      acc(1'b0, 7'(i), 8'h00, 1'b0);
      if (ack !== 1'b1) bad_ack++;
      if (data_out !== 8'h00) bad_data++;
      if (par_err !== 1'b0) bad_par++;
    end
    bus_idle();
    check("zero_read_ack_misses", bad_ack, 0);
    check("zero_read_nonzero", bad_data, 0);
    check("zero_read_par_err", bad_par, 0);
    tick();
    check("idle_ack_low", ack, 1'b0);

    // 2: push/pop
    acc(1'b1, 7'h7F, 8'h5A, 1'b0);
    check("push1_ack", ack, 1'b1);
    check("push1_through", data_out, 8'h5A);
    bus_idle(); tick();
    check("gap_ack", ack, 1'b0);
    check("gap_hold", data_out, 8'h5A);
    acc(1'b1, 7'h7E, 8'h33, 1'b0);
    check("push2_through", data_out, 8'h33);
    bus_idle(); tick();
    acc(1'b0, 7'h7F, 8'hEE, 1'b0);
    check("pop1_ack", ack, 1'b1);
    check("pop1_data", data_out, 8'h5A);
    acc(1'b0, 7'h7E, 8'hEE, 1'b0);
    check("pop2_data", data_out, 8'h33);
    bus_idle(); tick();
    check("pop_hold", data_out, 8'h33);

    // 3: four back-to-back accesses, read right after write
    acc(1'b1, 7'h10, 8'h11, 1'b0);
    check("b2b0_ack", ack, 1'b1);
    acc(1'b0, 7'h10, 8'h00, 1'b0);
    check("b2b1_ack", ack, 1'b1);
    check("b2b1_data", data_out, 8'h11);
    acc(1'b1, 7'h11, 8'h22, 1'b0);
    check("b2b2_ack", ack, 1'b1);
    check("b2b2_through", data_out, 8'h22);
    acc(1'b0, 7'h11, 8'h00, 1'b0);
    check("b2b3_ack", ack, 1'b1);
    check("b2b3_data", data_out, 8'h22);
    bus_idle(); tick();
    check("b2b_end_ack", ack, 1'b0);

    // 6: parity inject (par_err expected only when the feature is built in)
    acc(1'b1, 7'h20, 8'h07, 1'b1);
    check("par_write_no_err", par_err, 1'b0);
    acc(1'b1, 7'h21, 8'h07, 1'b0);
    acc(1'b0, 7'h20, 8'h00, 1'b0);
    check("par_bad_data", data_out, 8'h07);
    check("par_bad_flag", par_err, PAR_EN);
    acc(1'b0, 7'h21, 8'h00, 1'b0);
    check("par_clean_data", data_out, 8'h07);
    check("par_clean_flag", par_err, 1'b0);
    bus_idle(); tick();
    check("par_idle_flag", par_err, 1'b0);

    // 4: access during sweep sets sticky err and is dropped
    pulse_reset();
    check("rst2_err_clear", err, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    acc(1'b1, 7'h05, 8'hFF, 1'b0);
    bus_idle();
    check("busy_err_set", err, 1'b1);
    check("busy_no_ack", ack, 1'b0);
    wait_idle(n, acks);
    check("busy_err_sweep_rest", n, 118);
    check("busy_err_sticky", err, 1'b1);
    acc(1'b0, 7'h05, 8'h00, 1'b0);
    bus_idle();
    check("dropped_write_data", data_out, 8'h00);
    check("err_sticky_idle", err, 1'b1);
    rst = 1'b1; #1;
    check("rst_clears_err", err, 1'b0);
    check("rst_async_ack", ack, 1'b0);
    tick();
    rst = 1'b0;

    // 5: reset mid-sweep restarts the full sweep
    for (int i = 0; i < 60; i++) tick();
    check("mid_sweep_busy", busy, 1'b1);
    pulse_reset();
    wait_idle(n, acks);
    check("restart_sweep_len", n, 128);
    acc(1'b1, 7'h00, 8'h77, 1'b0);
    acc(1'b0, 7'h00, 8'h00, 1'b0);
    bus_idle();
    check("pre_clear_data", data_out, 8'h77);
    rst = 1'b1; #1;
    check("rst_async_data_out", data_out, 8'h00);
    tick();
    rst = 1'b0;
    wait_idle(n, acks);
    check("clear_sweep_len", n, 128);
    acc(1'b0, 7'h00, 8'hAA, 1'b0);
    bus_idle();
    check("clear_read_ack", ack, 1'b1);
    check("clear_read_data", data_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
